// File: rtl/cskipa_result_stage.sv
// Pipeline wrapper around a combinational carry-skip adder.
// Operand pairs are registered in a single stage (S1) and driven to the adder.
// The adder's {cout,sum} is captured into a small output FIFO.
// A saturating counter tracks how many captured results had a carry-out.
module cskipa_result_stage #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    output logic [WIDTH-1:0] o_add_term1,
    output logic [WIDTH-1:0] o_add_term2,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    input  logic             i_clr_count,
    output logic [CNT_W-1:0] o_ovf_count
);

    // Pointer width covers DEPTH entries; the occupancy count must also reach DEPTH.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(DEPTH);

    // Stage 1 operand register
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Output FIFO state
    logic [WIDTH:0]    mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    // Overflow counter
    logic [CNT_W-1:0] ovf_q, ovf_d;

    // Handshake events
    logic accept;
    logic pop;
    logic space;
    logic move;
    logic fifo_full;

    // Handshake decode: o_ready depends only on internal state and the consumer's i_ready,
    // so a full FIFO that is being popped still lets S1 drain and refill in one cycle.
    always_comb begin
        fifo_full = (fifo_cnt_q == DEPTH_C);
        o_valid   = (fifo_cnt_q != '0);
        pop       = o_valid & i_ready;
        space     = ~fifo_full | pop;
        move      = s1_valid_q & space;
        o_ready   = ~s1_valid_q | move;
        accept    = i_valid & o_ready;
    end

    // Stage 1 next state: operands hold their last value when the stage empties.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = i_add_term1;
            b_d        = i_add_term2;
        end else if (move) begin
            s1_valid_d = 1'b0;
        end
    end

    // FIFO pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (move) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({move, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Overflow counter next state: a clear discards any same-cycle increment.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clr_count) begin
            ovf_d = '0;
        end else if (move && i_cout && !(&ovf_q)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset; in-flight results are discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage: data needs no reset because the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (move) begin
            mem[wr_ptr_q] <= {i_cout, i_sum};
        end
    end

    // Outputs
    always_comb begin
        o_add_term1 = a_q;
        o_add_term2 = b_q;
        o_ovf_count = ovf_q;
        o_result    = o_valid ? mem[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_cskipa_result_stage.sv
// Self-checking bench for cskipa_result_stage (WIDTH=12, DEPTH=2, CNT_W=2).
// The bench stands in for the attached adder and keeps a queue-based model of
// the operand slot, result FIFO and overflow count.
module tb_cskipa_result_stage;

    localparam int W = 12;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [W-1:0]  i_add_term1 = '0;
    logic [W-1:0]  i_add_term2 = '0;
    logic [W-1:0]  o_add_term1;
    logic [W-1:0]  o_add_term2;
    logic [W-1:0]  i_sum;
    logic          i_cout;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [W:0]    o_result;
    logic          i_clr_count = 1'b0;
    logic [1:0]    o_ovf_count;

    int n_vec = 0;
    int n_bad = 0;

    cskipa_result_stage #(.WIDTH(W), .DEPTH(2), .CNT_W(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .o_add_term1 (o_add_term1),
        .o_add_term2 (o_add_term2),
        .i_sum       (i_sum),
        .i_cout      (i_cout),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .i_clr_count (i_clr_count),
        .o_ovf_count (o_ovf_count)
    );

    // Stand-in for the combinational carry-skip adder
    assign {i_cout, i_sum} = {1'b0, o_add_term1} + {1'b0, o_add_term2};

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_s1;
    logic [W-1:0] m_a, m_b;
    logic [W:0]  m_fifo[$];
    int          m_cnt;

    // Compare on the falling edge, then advance the model to the state after the next rising edge
    always @(negedge i_clk) begin
        bit m_pop, m_move, m_ready, m_acc;
        logic [W:0] m_res;
        if (!i_rst_n) begin
            m_s1 = 0; m_a = '0; m_b = '0; m_fifo.delete(); m_cnt = 0;
            check("rst_o_valid", 32'(o_valid), 32'd0);
            check("rst_o_result", 32'(o_result), 32'd0);
            check("rst_ovf", 32'(o_ovf_count), 32'd0);
            check("rst_term1", 32'(o_add_term1), 32'd0);
        end else begin
            m_pop   = (m_fifo.size() > 0) && i_ready;
            m_move  = m_s1 && ((m_fifo.size() < 2) || m_pop);
            m_ready = !m_s1 || m_move;
            m_acc   = i_valid && m_ready;
            check("o_ready", 32'(o_ready), 32'(m_ready));
            check("o_valid", 32'(o_valid), 32'(m_fifo.size() > 0));
            check("o_result", 32'(o_result), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
            check("ovf_count", 32'(o_ovf_count), 32'(m_cnt));
            check("term1", 32'(o_add_term1), 32'(m_a));
            check("term2", 32'(o_add_term2), 32'(m_b));
            if (m_pop) void'(m_fifo.pop_front());
            if (m_move) begin
                m_res = {1'b0, m_a} + {1'b0, m_b};
                m_fifo.push_back(m_res);
                if (!i_clr_count && m_res[W] && m_cnt < 3) m_cnt++;
            end
            if (i_clr_count) m_cnt = 0;
            if (m_acc) begin
                m_s1 = 1; m_a = i_add_term1; m_b = i_add_term2;
            end else if (m_move) begin
                m_s1 = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_valid = 0; i_clr_count = 0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, stalls, pops;
        i_rst_n = 0;
        cyc(); cyc();
        i_rst_n = 1;
        #1;
        check("ready_after_release", 32'(o_ready), 32'd1);
        cyc();

        // 1. Single op with carry-out, two-cycle latency
        i_ready = 1; i_valid = 1; i_add_term1 = 12'hFFF; i_add_term2 = 12'h001;
        cyc();
        i_valid = 0;
        check("t1_not_yet", 32'(o_valid), 32'd0);
        cyc();
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_result", 32'(o_result), 32'h1000);
        check("t1_ovf", 32'(o_ovf_count), 32'd1);
        idle(3);

        // 2. Stream 64 random pairs with no stalls
        stalls = 0; pops = 0;
        for (int k = 0; k < 64; k++) begin
            i_valid = 1; i_ready = 1;
            i_add_term1 = W'($urandom); i_add_term2 = W'($urandom);
            #1;
            if (!o_ready) stalls++;
            if (o_valid) pops++;
            cyc();
        end
        check("t2_stalls", 32'(stalls), 32'd0);
        check("t2_results", 32'(pops), 32'd62);
        idle(4);

        // 3. Backpressure: four offers, three accepted
        i_ready = 0; acc = 0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1; i_add_term1 = W'(k * 100 + 7); i_add_term2 = W'(k * 3 + 1);
            #1;
            if (o_ready) acc++;
            if (k < 3) cyc();
        end
        check("t3_accepted", 32'(acc), 32'd3);
        check("t3_ready_low", 32'(o_ready), 32'd0);
        cyc();
        i_valid = 0; i_ready = 1; pops = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (o_valid) pops++;
            cyc();
        end
        check("t3_drained", 32'(pops), 32'd3);

        // 4. Saturation and clear priority
        i_clr_count = 1; cyc(); i_clr_count = 0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1; i_add_term1 = 12'h800; i_add_term2 = 12'h800;
            cyc();
        end
        idle(3);
        check("t4_saturated", 32'(o_ovf_count), 32'd3);
        i_valid = 1; i_add_term1 = 12'h800; i_add_term2 = 12'h800;
        cyc();
        i_valid = 0; i_clr_count = 1;
        cyc();
        i_clr_count = 0;
        check("t4_clr_wins", 32'(o_ovf_count), 32'd0);
        idle(3);

        // 5. Reset with two results in flight
        i_ready = 0;
        for (int k = 0; k < 2; k++) begin
            i_valid = 1; i_add_term1 = 12'h800; i_add_term2 = 12'h801;
            cyc();
        end
        i_valid = 0;
        i_rst_n = 0;
        #1;
        check("t5_valid_cleared", 32'(o_valid), 32'd0);
        check("t5_ovf_cleared", 32'(o_ovf_count), 32'd0);
        cyc(); cyc();
        i_rst_n = 1;
        #1;
        check("t5_ready_release", 32'(o_ready), 32'd1);
        cyc();

        // 6. Full pipeline: accept, move and pop in a single cycle
        i_ready = 0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1; i_add_term1 = W'(k + 40); i_add_term2 = W'(k + 9);
            cyc();
        end
        i_ready = 1; i_valid = 1; i_add_term1 = 12'h123; i_add_term2 = 12'h456;
        #1;
        check("t6_ready_with_pop", 32'(o_ready), 32'd1);
        cyc();
        i_ready = 0; i_valid = 0;
        #1;
        check("t6_still_full", 32'(o_ready), 32'd0);
        check("t6_valid", 32'(o_valid), 32'd1);
        i_ready = 1;
        idle(5);

        // Random traffic with random backpressure and occasional clears
        for (int k = 0; k < 400; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_clr_count = ($urandom_range(0, 15) == 0);
            i_add_term1 = W'($urandom); i_add_term2 = W'($urandom);
            cyc();
        end
        i_ready = 1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
